load_store_unit: RTL and testbench

- Memory stage directly downstream of the integer ALU. It takes the ALU result as the effective address, plus the store data, destination register and access type.
- It runs one request/grant/response transaction on the data-memory port at a time, with byte-lane steering.
- It returns aligned, sign- or zero-extended load data to writeback.
- It flags misaligned accesses instead of issuing them.

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory stage: turns ALU effective addresses into single request/grant/response
// transactions on the data port, steering byte lanes and extending load data for writeback.
module load_store_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      exValid,
    output logic                      exReady,
    input  logic                      exStore,
    input  logic [2:0]                exFunct3,
    input  logic [WIDTH-1:0]          exAddr,
    input  logic [WIDTH-1:0]          exWdata,
    input  logic [REG_ADDR_WIDTH-1:0] exRd,
    output logic                      memReq,
    output logic                      memWe,
    output logic [WIDTH-1:0]          memAddr,
    output logic [3:0]                memBe,
    output logic [WIDTH-1:0]          memWdata,
    input  logic                      memGnt,
    input  logic                      memRvalid,
    input  logic [WIDTH-1:0]          memRdata,
    output logic                      wbValid,
    output logic [REG_ADDR_WIDTH-1:0] wbRd,
    output logic [WIDTH-1:0]          wbData,
    output logic                      storeDone,
    output logic                      misalign,
    output logic [WIDTH-1:0]          badAddr
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    state_e                    state_q, state_d;
    size_e                     size_q, size_d, ex_size;
    logic                      store_q, store_d;
    logic                      uns_q, uns_d, ex_uns;
    logic [1:0]                off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]          mem_addr_q, mem_addr_d;
    logic [3:0]                mem_be_q, mem_be_d, ex_be;
    logic [WIDTH-1:0]          mem_wdata_q, mem_wdata_d, ex_wdata;
    logic                      wb_valid_q, wb_valid_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0]          wb_data_q, wb_data_d, ld_ext, ld_shift;
    logic                      store_done_q, store_done_d;
    logic                      misalign_q, misalign_d;
    logic [WIDTH-1:0]          bad_addr_q, bad_addr_d;
    logic                      ex_misaligned;

    // Access decode; unsigned funct3 on a store and reserved encodings fall back to word.
    always_comb begin
        ex_size = SzWord;
        ex_uns  = 1'b0;
        case (exFunct3)
            3'b000: ex_size = SzByte;
            3'b001: ex_size = SzHalf;
            3'b100: begin
                ex_size = exStore ? SzWord : SzByte;
                ex_uns  = ~exStore;
            end
            3'b101: begin
                ex_size = exStore ? SzWord : SzHalf;
                ex_uns  = ~exStore;
            end
            default: ex_size = SzWord;
        endcase
    end

    always_comb begin
        ex_misaligned = 1'b0;
        ex_be         = 4'b1111;
        ex_wdata      = exWdata;
        case (ex_size)
            SzByte: begin
                ex_be    = 4'b0001 << exAddr[1:0];
                ex_wdata = {4{exWdata[7:0]}};
            end
            SzHalf: begin
                ex_misaligned = exAddr[0];
                ex_be         = 4'b0011 << exAddr[1:0];
                ex_wdata      = {2{exWdata[15:0]}};
            end
            default: ex_misaligned = (exAddr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        ld_shift = memRdata >> {off_q, 3'b000};
        case (size_q)
            SzByte:  ld_ext = uns_q ? {24'b0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SzHalf:  ld_ext = uns_q ? {16'b0, ld_shift[15:0]}
                                    : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = memRdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        store_d      = store_q;
        uns_d        = uns_q;
        off_d        = off_q;
        rd_d         = rd_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        store_done_d = 1'b0;
        misalign_d   = 1'b0;
        bad_addr_d   = bad_addr_q;
        unique case (state_q)
            StIdle: begin
                if (exValid) begin
                    size_d  = ex_size;
                    store_d = exStore;
                    uns_d   = ex_uns;
                    off_d   = exAddr[1:0];
                    rd_d    = exRd;
                    if (ex_misaligned) begin
                        misalign_d = 1'b1;
                        bad_addr_d = exAddr;
                    end else begin
                        mem_addr_d  = {exAddr[WIDTH-1:2], 2'b00};
                        mem_be_d    = ex_be;
                        mem_wdata_d = ex_wdata;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (memGnt) begin
                    if (store_q) begin
                        store_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (memRvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = ld_ext;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            size_q       <= SzWord;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            rd_q         <= '0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
            misalign_q   <= 1'b0;
            bad_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            store_q      <= store_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
            misalign_q   <= misalign_d;
            bad_addr_q   <= bad_addr_d;
        end
    end

    assign exReady   = (state_q == StIdle);
    assign memReq    = (state_q == StReq);
    assign memWe     = (state_q == StReq) & store_q;
    assign memAddr   = mem_addr_q;
    // Lane enables stay registered after a transaction; only memReq qualifies them.
    assign memBe     = mem_be_q;
    assign memWdata  = mem_wdata_q;
    assign wbValid   = wb_valid_q;
    assign wbRd      = wb_rd_q;
    assign wbData    = wb_data_q;
    assign storeDone = store_done_q;
    assign misalign  = misalign_q;
    assign badAddr   = bad_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues ops and queues expectations from a
// byte-level reference model; a memory responder and an output monitor check independently.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        exValid = 1'b0, exReady, exStore = 1'b0;
    logic [2:0]  exFunct3 = 3'd0;
    logic [31:0] exAddr = '0, exWdata = '0;
    logic [4:0]  exRd = '0;
    logic        memReq, memWe, memGnt = 1'b0, memRvalid = 1'b0;
    logic [31:0] memAddr, memWdata, memRdata = '0;
    logic [3:0]  memBe;
    logic        wbValid, storeDone, misalign;
    logic [4:0]  wbRd;
    logic [31:0] wbData, badAddr;

    load_store_unit #(.WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rstn(rstn),
        .exValid(exValid), .exReady(exReady), .exStore(exStore), .exFunct3(exFunct3),
        .exAddr(exAddr), .exWdata(exWdata), .exRd(exRd),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe),
        .memWdata(memWdata), .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata),
        .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData),
        .storeDone(storeDone), .misalign(misalign), .badAddr(badAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        int          rvd;
        bit          abort;
    } req_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    req_t        req_q[$];
    wb_t         wb_q[$];
    logic [31:0] mis_q[$];
    int          exp_store = 0;
    bit          abort_granted = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: access width in bytes, lanes, replicated store data, extended load.
    function automatic int nbytes(input bit st, input logic [2:0] f3);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd4: return st ? 4 : 1;
            3'd5: return st ? 4 : 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input int n,
                                               input int off, input logic [31:0] rdata);
        logic [31:0] m, v;
        int bits;
        bits = 8 * n;
        m = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
        v = (rdata >> (8 * off)) & m;
        if (n < 4 && f3 != 3'd4 && f3 != 3'd5 && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int gd, input int rvd,
                         input bit abort, output bit done_seen);
        int   n, off, waited;
        req_t r;
        wb_t  w;
        n = nbytes(st, f3);
        off = int'(addr % 4);
        waited = 0;
        @(negedge clk);
        while (exReady !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL ex_ready_timeout: exReady=%b after %0d cycles, required 1", exReady,
                     waited);
        end
        done_seen = storeDone;
        if ((addr % n) != 0) begin
            mis_q.push_back(addr);
        end else begin
            r.addr  = addr - (addr % 4);
            r.be    = 4'(((1 << n) - 1) << off);
            r.we    = st;
            r.wdata = (n == 1) ? wdata[7:0] * 32'h0101_0101 :
                      (n == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
            r.rdata = rdata;
            r.gd    = gd;
            r.rvd   = rvd;
            r.abort = abort;
            req_q.push_back(r);
            if (st) exp_store++;
            else if (!abort) begin
                w.rd   = rd;
                w.data = load_model(f3, n, off, rdata);
                wb_q.push_back(w);
            end
        end
        exValid = 1'b1; exStore = st; exFunct3 = f3; exAddr = addr; exWdata = wdata; exRd = rd;
        @(posedge clk);
        #1;
        exValid = 1'b0; exAddr = $urandom; exWdata = $urandom; exRd = 5'($urandom);
    endtask

    task automatic check_req(input string name, input req_t r);
        check({name, "_req"}, memReq, 1'b1);
        check({name, "_addr"}, memAddr, r.addr);
        check({name, "_be"}, memBe, r.be);
        check({name, "_we"}, memWe, r.we);
        check({name, "_wdata"}, memWdata, r.wdata);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, exReady, 1'b1);
        check({name, "_ctrl"}, {memReq, memWe, wbValid, storeDone, misalign, memBe, wbRd}, 0);
        check({name, "_mem_addr"}, memAddr, 0);
        check({name, "_mem_wdata"}, memWdata, 0);
        check({name, "_wb_data"}, wbData, 0);
        check({name, "_bad_addr"}, badAddr, 0);
    endtask

    initial begin : responder
        req_t r;
        forever begin
            @(negedge clk);
            if (memReq === 1'b1) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: memReq=1 addr %0h, required no request",
                             memAddr);
                    memGnt = 1'b1;
                    @(posedge clk);
                    #1 memGnt = 1'b0;
                end else begin
                    r = req_q.pop_front();
                    check_req("req", r);
                    for (int k = 0; k < r.gd; k++) begin
                        memRvalid = 1'($urandom_range(0, 1));
                        memRdata  = $urandom;
                        @(negedge clk);
                        check_req("req_hold", r);
                        check("req_hold_ready", exReady, 1'b0);
                    end
                    memRvalid = 1'b0;
                    memGnt = 1'b1;
                    @(posedge clk);
                    #1 memGnt = 1'b0;
                    if (r.abort) begin
                        abort_granted = 1'b1;
                    end else if (!r.we) begin
                        repeat (r.rvd) begin
                            @(posedge clk);
                            #1;
                        end
                        memRvalid = 1'b1;
                        memRdata  = r.rdata;
                        @(posedge clk);
                        #1 memRvalid = 1'b0;
                        memRdata  = $urandom;
                    end
                end
            end
        end
    end

    initial begin : monitor
        wb_t w;
        logic [31:0] b;
        forever begin
            @(negedge clk);
            if (wbValid === 1'b1) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wb: wbValid=1 rd %0d data %0h, required none",
                             wbRd, wbData);
                end else begin
                    w = wb_q.pop_front();
                    check("wb_data", wbData, w.data);
                    check("wb_rd", wbRd, w.rd);
                    check("wb_ready", exReady, 1'b1);
                end
            end
            if (storeDone === 1'b1) begin
                if (exp_store == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_store_done: storeDone=1, required 0");
                end else begin
                    exp_store--;
                    check("store_done_ready", exReady, 1'b1);
                end
            end
            if (misalign === 1'b1) begin
                if (mis_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_misalign: misalign=1 badAddr %0h, required 0",
                             badAddr);
                end else begin
                    b = mis_q.pop_front();
                    check("bad_addr", badAddr, b);
                    check("misalign_ready", exReady, 1'b1);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit          sd;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          waited;
        #1;
        check_reset_outputs("reset_init");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Directed cases.
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0, 1'b0, sd);
        do_op(1'b0, 3'b000, 32'h203, 32'h0, 5'd6, 32'h80FF_FF7F, 1, 0, 1'b0, sd);
        do_op(1'b0, 3'b100, 32'h203, 32'h0, 5'd7, 32'h80FF_FF7F, 0, 2, 1'b0, sd);
        do_op(1'b1, 3'b001, 32'h302, 32'h1234_ABCD, 5'd0, 32'h0, 3, 0, 1'b0, sd);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd8, 32'h0, 0, 0, 1'b0, sd);
        do_op(1'b1, 3'b000, 32'h011, 32'h0000_005A, 5'd0, 32'h0, 0, 0, 1'b0, sd);
        do_op(1'b0, 3'b001, 32'h006, 32'h0, 5'd9, 32'h8123_0000, 0, 1, 1'b0, sd);
        check("b2b_accept_in_done_cycle", sd, 1'b1);
        @(negedge clk);
        check("b2b_second_req", memReq, 1'b1);
        check("b2b_second_be", memBe, 4'b1100);

        // Reset while waiting for read data; the late memRvalid must be ignored.
        repeat (8) @(negedge clk);
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd3, 32'h0, 1, 0, 1'b1, sd);
        waited = 0;
        @(negedge clk);
        while (!abort_granted && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("abort_granted", abort_granted, 1'b1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_wait");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 memRvalid = 1'b1;
        memRdata = 32'h1357_9BDF;
        @(posedge clk);
        #1 memRvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_no_wb", wbValid, 1'b0);
            check("post_reset_ready", exReady, 1'b1);
        end

        // Randomized ops.
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(st, f3, addr, $urandom, 5'($urandom), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, sd);
        end

        waited = 0;
        while ((req_q.size() + wb_q.size() + mis_q.size() + exp_store) != 0 && waited < 200)
        begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", req_q.size() + wb_q.size() + mis_q.size() + exp_store, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
